obstacle_sequencer: RTL

- Upstream stage of the obstacle mux. Drives its 4-bit select in place of the board switches, so obstacles appear in a timed sequence with gaps.
- Counts frames on vsync, steps through NUM_OBSTACLES obstacles, and inserts GAP_FRAMES of "no obstacle" between them.
- Issues a one-cycle start pulse so obstacle generators restart their motion.
- Freezes on game_over; returns to idle when the menu deselects play.

---
 rtl/obstacle_pkg.sv | 19 +
 rtl/frame_tick_gen.sv | 18 +
 rtl/obstacle_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle sequencer slice.
package obstacle_pkg;

  localparam int unsigned SEL_W  = 4;
  localparam int unsigned RND_W  = 8;
  localparam int unsigned LFSR_W = 16;

  // Galois LFSR, taps 16,14,13,11 in right-shift form
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vsync; tick_c is high for the cycle vsync is first seen high.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic tick_c
);

  logic vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_q <= 1'b0;
    else        vsync_q <= vsync_in;
  end

  assign tick_c = vsync_in & ~vsync_q;

endmodule

// File: rtl/obstacle_sequencer.sv
// Drives the obstacle mux select through timed obstacle/gap phases counted in frames.
// Optional randomized obstacle order: define OBSTACLE_SEQ_RANDOM_EN.
module obstacle_sequencer
  import obstacle_pkg::*;
#(
  parameter int unsigned NUM_OBSTACLES   = 2,
  parameter int unsigned OBSTACLE_FRAMES = 600,
  parameter int unsigned GAP_FRAMES      = 120,
  parameter int unsigned GAP_SEL         = 15
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             play_selected,
  input  logic             game_over,
  output logic [SEL_W-1:0] obstacle_select,
  output logic             obstacle_start,
  output logic [RND_W-1:0] round_count,
  output logic             seq_active
);

  localparam int unsigned MAX_FRAMES = (OBSTACLE_FRAMES > GAP_FRAMES) ? OBSTACLE_FRAMES : GAP_FRAMES;
  localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0] OBS_LAST = CNT_W'(OBSTACLE_FRAMES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_FRAMES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_OBSTACLES - 1);
  localparam logic [SEL_W-1:0] SEL_GAP  = SEL_W'(GAP_SEL);
  localparam logic [RND_W-1:0] RND_MAX  = '1;

  seq_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_nxt;
  logic [SEL_W-1:0] idx_q, idx_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             start_nxt;
  logic [RND_W-1:0] round_nxt;
  logic             active_nxt;

  logic             tick_c;
  logic [SEL_W-1:0] idx_inc_c;
  logic [SEL_W-1:0] next_idx_c;
  logic             round_step_c;

  frame_tick_gen u_tick (
    .clk      (pclk),
    .rst_n    (rst),
    .vsync_in (vsync_in),
    .tick_c   (tick_c)
  );

  assign idx_inc_c = (idx_q == IDX_LAST) ? '0 : idx_q + SEL_W'(1);

`ifdef OBSTACLE_SEQ_RANDOM_EN
  logic [LFSR_W-1:0] lfsr_q;
  logic [SEL_W-1:0]  lfsr_pick_c;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst)          lfsr_q <= LFSR_SEED;
    else if (lfsr_q[0]) lfsr_q <= (lfsr_q >> 1) ^ LFSR_TAPS;
    else               lfsr_q <= lfsr_q >> 1;
  end

  // Never pick the obstacle that just ran
  assign lfsr_pick_c  = SEL_W'(32'(lfsr_q[3:0]) % NUM_OBSTACLES);
  assign next_idx_c   = (lfsr_pick_c == idx_q) ? idx_inc_c : lfsr_pick_c;
  assign round_step_c = 1'b1;
`else
  assign next_idx_c   = idx_inc_c;
  assign round_step_c = (idx_q == IDX_LAST);
`endif

  // State and registered outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      frame_cnt_q     <= '0;
      idx_q           <= '0;
      obstacle_select <= SEL_GAP;
      obstacle_start  <= 1'b0;
      round_count     <= '0;
      seq_active      <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      frame_cnt_q     <= frame_cnt_nxt;
      idx_q           <= idx_nxt;
      obstacle_select <= sel_nxt;
      obstacle_start  <= start_nxt;
      round_count     <= round_nxt;
      seq_active      <= active_nxt;
    end
  end

  // Next state: game_over beats menu exit, which beats the frame timers
  always_comb begin
    state_nxt     = state_q;
    frame_cnt_nxt = frame_cnt_q;
    idx_nxt       = idx_q;
    round_nxt     = round_count;
    sel_nxt       = SEL_GAP;
    start_nxt     = 1'b0;
    active_nxt    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (play_selected && !game_over) begin
          state_nxt     = ST_PLAY;
          idx_nxt       = '0;
          frame_cnt_nxt = '0;
          sel_nxt       = '0;
          start_nxt     = 1'b1;
          round_nxt     = '0;
          active_nxt    = 1'b1;
        end
      end

      ST_PLAY: begin
        if (game_over) begin
          state_nxt = ST_HALT;
        end else if (!play_selected) begin
          state_nxt = ST_IDLE;
        end else begin
          sel_nxt    = idx_q;
          active_nxt = 1'b1;
          if (tick_c) begin
            if (frame_cnt_q == OBS_LAST) begin
              state_nxt     = ST_GAP;
              frame_cnt_nxt = '0;
              sel_nxt       = SEL_GAP;
            end else begin
              frame_cnt_nxt = frame_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_GAP: begin
        if (game_over) begin
          state_nxt = ST_HALT;
        end else if (!play_selected) begin
          state_nxt = ST_IDLE;
        end else begin
          active_nxt = 1'b1;
          if (tick_c) begin
            if (frame_cnt_q == GAP_LAST) begin
              state_nxt     = ST_PLAY;
              idx_nxt       = next_idx_c;
              frame_cnt_nxt = '0;
              sel_nxt       = next_idx_c;
              start_nxt     = 1'b1;
              if (round_step_c && (round_count != RND_MAX)) round_nxt = round_count + RND_W'(1);
            end else begin
              frame_cnt_nxt = frame_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_HALT: begin
        if (!play_selected) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
